// File: rtl/mem_access_stage.sv
// Memory-access stage: lbu/lhu/lw/sb/sh/sw over a req/ack word-wide memory port.
// Define MEM_BYTE_LANES_EN for byte-enable writes; otherwise sub-word stores use read-modify-write.
module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        START,
    input  logic [4:0]  OP,
    input  logic [31:0] ADDR,
    input  logic [31:0] WDATA,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [31:0] RDATA,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [31:0] MEM_ADDR,
    output logic [31:0] MEM_WDATA,
    input  logic [31:0] MEM_RDATA,
    input  logic        MEM_ACK
`ifdef MEM_BYTE_LANES_EN
    ,
    output logic [3:0]  MEM_BE
`endif
);

    localparam logic [4:0] OP_LBU = 5'd12;
    localparam logic [4:0] OP_LHU = 5'd13;
    localparam logic [4:0] OP_LW  = 5'd14;
    localparam logic [4:0] OP_SB  = 5'd15;
    localparam logic [4:0] OP_SH  = 5'd16;
    localparam logic [4:0] OP_SW  = 5'd17;
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_FIN} state_t;

    state_t        state_q, state_d;
    logic [4:0]    op_q;
    logic [31:0]   addr_q;
    logic [31:0]   wword_q;
    logic [31:0]   rdata_q;
    logic          err_q;
    logic [CW-1:0] cnt_q;

    logic          in_err, in_direct_wr;
    logic          q_load, tmo_hit, in_xfer;
    logic [31:0]   load_word;

`ifdef MEM_BYTE_LANES_EN
    logic [3:0]    be_q;
    logic [3:0]    in_be;
    logic [31:0]   in_wword;
`else
    logic [31:0]   wdata_q;
    logic [31:0]   merged;
`endif

    // Request decode on the live inputs, used only at the IDLE->busy edge.
    always_comb begin
        in_err = !(OP >= OP_LBU && OP <= OP_SW)
               || ((OP == OP_LHU || OP == OP_SH) && ADDR[0])
               || ((OP == OP_LW  || OP == OP_SW) && (ADDR[1:0] != 2'b00));
`ifdef MEM_BYTE_LANES_EN
        in_direct_wr = (OP == OP_SB) || (OP == OP_SH) || (OP == OP_SW);
        in_be        = 4'b0000;
        in_wword     = WDATA;
        case (OP)
            OP_SB: begin
                in_be    = 4'b0001 << ADDR[1:0];
                in_wword = {4{WDATA[7:0]}};
            end
            OP_SH: begin
                in_be    = 4'b0011 << {ADDR[1], 1'b0};
                in_wword = {2{WDATA[15:0]}};
            end
            OP_SW:   in_be = 4'b1111;
            default: in_be = 4'b0000;
        endcase
`else
        in_direct_wr = (OP == OP_SW);
`endif
    end

    always_comb begin
        q_load    = (op_q == OP_LBU) || (op_q == OP_LHU) || (op_q == OP_LW);
        in_xfer   = (state_q == S_RD) || (state_q == S_WR);
        tmo_hit   = (TIMEOUT_CYCLES != 0) && ((32'(cnt_q) + 32'd1) >= TIMEOUT_CYCLES);
        load_word = MEM_RDATA;
        case (op_q)
            OP_LBU:  load_word = {24'h0, MEM_RDATA[{addr_q[1:0], 3'b000} +: 8]};
            OP_LHU:  load_word = {16'h0, MEM_RDATA[{addr_q[1], 4'b0000} +: 16]};
            default: load_word = MEM_RDATA;
        endcase
`ifndef MEM_BYTE_LANES_EN
        merged = MEM_RDATA;
        if (op_q == OP_SB)
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (START) begin
                if (in_err)            state_d = S_FIN;
                else if (in_direct_wr) state_d = S_WR;
                else                   state_d = S_RD;
            end
            S_RD: begin
                if (MEM_ACK)      state_d = q_load ? S_FIN : S_WR;
                else if (tmo_hit) state_d = S_FIN;
            end
            S_WR: if (MEM_ACK || tmo_hit) state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            wword_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
`ifdef MEM_BYTE_LANES_EN
            be_q    <= '0;
`else
            wdata_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (state_d != state_q)
                cnt_q <= '0;
            else if (in_xfer && !MEM_ACK)
                cnt_q <= cnt_q + 1'b1;

            if (state_q == S_IDLE && START) begin
                op_q   <= OP;
                addr_q <= ADDR;
                err_q  <= in_err;
`ifdef MEM_BYTE_LANES_EN
                be_q    <= in_be;
                wword_q <= in_wword;
`else
                wdata_q <= WDATA;
                wword_q <= WDATA;
`endif
            end

            if (in_xfer && !MEM_ACK && tmo_hit)
                err_q <= 1'b1;

            if (state_q == S_RD && MEM_ACK) begin
                if (q_load)
                    rdata_q <= load_word;
`ifndef MEM_BYTE_LANES_EN
                else
                    wword_q <= merged;
`endif
            end
        end
    end

    // Request-side outputs decode straight from state so a reset edge drops MEM_REQ at once.
    assign BUSY      = (state_q != S_IDLE);
    assign DONE      = (state_q == S_FIN);
    assign ERR       = (state_q == S_FIN) && err_q;
    assign RDATA     = rdata_q;
    assign MEM_REQ   = in_xfer;
    assign MEM_WE    = (state_q == S_WR);
    assign MEM_ADDR  = {addr_q[31:2], 2'b00};
    assign MEM_WDATA = wword_q;
`ifdef MEM_BYTE_LANES_EN
    assign MEM_BE    = (state_q == S_WR) ? be_q : 4'b0000;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: word-memory model plus arithmetic reference for loads/stores.
module tb_mem_access_stage;

    localparam int TMO = 4;

    logic        clock = 1'b0;
    logic        reset, START, MEM_ACK;
    logic [4:0]  OP;
    logic [31:0] ADDR, WDATA, MEM_RDATA;
    logic        BUSY, DONE, ERR, MEM_REQ, MEM_WE;
    logic [31:0] RDATA, MEM_ADDR, MEM_WDATA;
`ifdef MEM_BYTE_LANES_EN
    logic [3:0]  MEM_BE;
    localparam bit LANES = 1'b1;
`else
    localparam bit LANES = 1'b0;
`endif

    int tests = 0;
    int fails = 0;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] rd_model = 32'h0;

    mem_access_stage #(.TIMEOUT_CYCLES(TMO)) dut (
        .clock(clock), .reset(reset), .START(START), .OP(OP), .ADDR(ADDR), .WDATA(WDATA),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .RDATA(RDATA),
        .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
        .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK)
`ifdef MEM_BYTE_LANES_EN
        , .MEM_BE(MEM_BE)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rdm(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    // Drives one operation and acts as the memory; samples on the falling edge.
    task automatic run_op(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          input int dly, output int done_cyc, output logic err_o, output int reqs,
                          output logic stable, output logic [31:0] first_addr, output logic [3:0] last_be);
        logic [31:0] pa, pd;
        logic pw, have_prev;
        int w;
        @(negedge clock);
        START = 1'b1; OP = op; ADDR = addr; WDATA = wd; MEM_ACK = 1'b0;
        @(negedge clock);
        START = 1'b0; ADDR = $urandom; WDATA = $urandom; OP = 5'($urandom);
        done_cyc = -1; err_o = 1'bx; reqs = 0; stable = 1'b1; first_addr = 32'hFFFF_FFFF;
        last_be = 4'h0; w = 0; have_prev = 1'b0; pa = 0; pd = 0; pw = 0;
        for (int c = 1; c <= 60; c++) begin
            MEM_ACK = 1'b0;
            MEM_RDATA = $urandom;
            if (DONE) begin
                done_cyc = c; err_o = ERR; START = 1'b0;
                break;
            end
            if (MEM_REQ) begin
                if (reqs == 0) first_addr = MEM_ADDR;
                reqs++;
                if (have_prev && (MEM_ADDR !== pa || MEM_WE !== pw || MEM_WDATA !== pd)) stable = 1'b0;
                if (MEM_ADDR[1:0] !== 2'b00) stable = 1'b0;
                if (w == dly) begin
                    MEM_ACK = 1'b1;
                    if (MEM_WE) begin
`ifdef MEM_BYTE_LANES_EN
                        logic [31:0] nw;
                        nw = rdm(MEM_ADDR);
                        for (int k = 0; k < 4; k++)
                            if (MEM_BE[k]) nw[8*k +: 8] = MEM_WDATA[8*k +: 8];
                        mem[MEM_ADDR] = nw;
                        last_be = MEM_BE;
`else
                        mem[MEM_ADDR] = MEM_WDATA;
`endif
                    end else begin
                        MEM_RDATA = rdm(MEM_ADDR);
                    end
                    w = 0; have_prev = 1'b0;
                end else begin
                    w++; have_prev = 1'b1;
                    pa = MEM_ADDR; pw = MEM_WE; pd = MEM_WDATA;
                end
            end else begin
                have_prev = 1'b0;
            end
            START = ($urandom_range(0, 3) == 0);  // must be ignored while busy
            @(negedge clock);
        end
        MEM_ACK = 1'b0;
        START = 1'b0;
    endtask

    // Reference: expected results derived from op size, lane offset and ack delay.
    task automatic check_op(input string tag, input logic [4:0] op, input logic [31:0] addr,
                            input logic [31:0] wd, input int dly);
        int size, sh, e_cyc, e_reqs, cyc, reqs;
        logic legal, is_load, is_store, e_err, err_o, stable;
        logic [31:0] wa, old, e_mem, e_rd, fa;
        logic [63:0] mask64;
        logic [31:0] mask;
        logic [3:0] be;
        legal    = (op >= 12 && op <= 17);
        is_load  = (op >= 12 && op <= 14);
        is_store = (op >= 15 && op <= 17);
        size = (op == 12 || op == 15) ? 1 : (op == 13 || op == 16) ? 2 : 4;
        e_err = !legal || (size == 2 && addr[0]) || (size == 4 && addr[1:0] != 2'b00);
        wa = {addr[31:2], 2'b00};
        old = rdm(wa);
        sh = (size == 1) ? 8 * int'(addr[1:0]) : (size == 2) ? 16 * int'(addr[1]) : 0;
        mask64 = (64'd1 << (8 * size)) - 64'd1;
        mask = mask64[31:0];
        e_mem = old; e_rd = rd_model;
        if (e_err) begin
            e_cyc = 1; e_reqs = 0;
        end else if (dly >= TMO) begin
            e_err = 1'b1; e_cyc = TMO + 1; e_reqs = TMO;
        end else if (is_load) begin
            e_rd = (old >> sh) & mask; e_cyc = dly + 2; e_reqs = dly + 1;
        end else begin
            e_mem = (old & ~(mask << sh)) | ((wd & mask) << sh);
            if (op == 17 || LANES) begin e_cyc = dly + 2; e_reqs = dly + 1; end
            else begin e_cyc = 2 * dly + 3; e_reqs = 2 * dly + 2; end
        end
        run_op(op, addr, wd, dly, cyc, err_o, reqs, stable, fa, be);
        chk({tag, " done_cycle"}, 32'(cyc), 32'(e_cyc));
        chk({tag, " err"}, {31'h0, err_o}, {31'h0, e_err});
        chk({tag, " req_cycles"}, 32'(reqs), 32'(e_reqs));
        chk({tag, " rdata"}, RDATA, e_rd);
        chk({tag, " mem_word"}, rdm(wa), e_mem);
        chk({tag, " req_stable"}, {31'h0, stable}, 32'h1);
        if (e_reqs > 0) chk({tag, " mem_addr"}, fa, wa);
        if (is_store && !e_err && LANES)
            chk({tag, " mem_be"}, {28'h0, be},
                {28'h0, (op == 15) ? (4'b0001 << addr[1:0]) : (op == 16) ? (4'b0011 << {addr[1], 1'b0}) : 4'b1111});
        rd_model = e_rd;
    endtask

    initial begin
        logic [4:0] rop;
        logic [31:0] raddr;
        reset = 1'b1; START = 1'b0; OP = '0; ADDR = '0; WDATA = '0; MEM_RDATA = '0; MEM_ACK = 1'b0;
        for (int i = 0; i < 16; i++) mem[32'h1000 + 32'(4 * i)] = $urandom;
        mem[32'h100] = 32'h1122_3344;
        mem[32'h200] = 32'hAABB_CCDD;
        mem[32'h300] = 32'h5555_AAAA;
        repeat (3) @(negedge clock);
        // reset values
        chk("rst busy", {31'h0, BUSY}, 32'h0);
        chk("rst done", {31'h0, DONE}, 32'h0);
        chk("rst err", {31'h0, ERR}, 32'h0);
        chk("rst rdata", RDATA, 32'h0);
        chk("rst req_we", {30'h0, MEM_REQ, MEM_WE}, 32'h0);
        chk("rst mem_addr", MEM_ADDR, 32'h0);
        chk("rst mem_wdata", MEM_WDATA, 32'h0);
        reset = 1'b0;

        check_op("lbu_0x102", 5'd12, 32'h102, 32'h0, 0);
        chk("lbu_0x102 value", RDATA, 32'h0000_0022);
        check_op("sb_0x201", 5'd15, 32'h201, 32'h0000_00EE, 0);
        chk("sb_0x201 value", rdm(32'h200), 32'hAABB_EEDD);
        check_op("lw_mis", 5'd14, 32'h302, 32'h0, 0);
        check_op("op18", 5'd18, 32'h300, 32'h0, 0);
        check_op("sh_mis", 5'd16, 32'h301, 32'h1234, 0);
        check_op("sw_dly3", 5'd17, 32'h400, 32'hDEAD_BEEF, 3);
        chk("sw_dly3 value", rdm(32'h400), 32'hDEAD_BEEF);
        check_op("lhu_hi", 5'd13, 32'h402, 32'h0, 1);
        chk("lhu_hi value", RDATA, 32'h0000_DEAD);
        check_op("lw_tmo", 5'd14, 32'h100, 32'h0, 100);
        check_op("sh_tmo", 5'd16, 32'h202, 32'h7777, 100);

        // reset while in RD: request must drop with no DONE
        @(negedge clock);
        START = 1'b1; OP = 5'd14; ADDR = 32'h300;
        @(negedge clock);
        START = 1'b0;
        chk("rd req_high", {31'h0, MEM_REQ}, 32'h1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("rst_mid req", {31'h0, MEM_REQ}, 32'h0);
        chk("rst_mid busy", {31'h0, BUSY}, 32'h0);
        chk("rst_mid done", {31'h0, DONE}, 32'h0);
        @(negedge clock);
        chk("rst_mid no_done", {31'h0, DONE}, 32'h0);
        rd_model = 32'h0;
        check_op("after_rst lw", 5'd14, 32'h300, 32'h0, 0);

        for (int n = 0; n < 40; n++) begin
            rop = 5'($urandom_range(11, 18));
            raddr = 32'h1000 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            check_op($sformatf("rnd%0d op%0d", n, rop), rop, raddr, $urandom, $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
